nes_controller: RTL
===================

NES_CONTROLLER -- requirements
Module: nes_controller

Interface
REQ-001 SHALL have parameter HALF_DIV, default 75, meaning clk cycles per half serial-clock period (3 us at 25 MHz); legal range HALF_DIV >= 2.
REQ-002 SHALL have parameter POLL_CYCLES, default 416667, meaning clk cycles from one nes_latch rise to the next (60 Hz at 25 MHz); legal range POLL_CYCLES > 20*HALF_DIV+2.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port nes_data, input, 1 bit: controller serial data, active-low (0 = pressed), asynchronous to clk.
REQ-006 SHALL have port nes_latch, output, 1 bit: controller latch strobe, active-high.
REQ-007 SHALL have port nes_clk, output, 1 bit: controller shift clock, idles low.
REQ-008 SHALL have port buttons, output, 8 bits: active-high pressed flags, bit7..bit0 = A, B, Select, Start, Up, Down, Left, Right.
REQ-009 SHALL have port dpad, output, 4 bits: active-high direction flags, bit3..bit0 = right, up, down, left, for the frog movement input.
REQ-010 SHALL have port valid, output, 1 bit: one-cycle pulse when buttons/dpad update.

Function
REQ-011 SHALL pass nes_data through a two-flop synchronizer; all samples use the synchronized value.
REQ-012 SHALL implement states IDLE, LATCH, LOW, HIGH, DONE.
REQ-013 IDLE: nes_latch=0, nes_clk=0; free-running poll counter; enter LATCH when counter reaches POLL_CYCLES-1, counter wraps to 0.
REQ-014 LATCH: nes_latch=1 for exactly 4*HALF_DIV cycles, then enter LOW with bit index 0.
REQ-015 LOW: nes_clk=0 for HALF_DIV cycles; in the last LOW cycle sample the inverted synchronized data into shift bit (7 - index); then enter HIGH.
REQ-016 HIGH: nes_clk=1 for HALF_DIV cycles; then, if index < 7, increment index and enter LOW, else enter DONE.
REQ-017 Each frame SHALL produce exactly 8 nes_clk pulses with period 2*HALF_DIV cycles; total frame length is 20*HALF_DIV+1 cycles.
REQ-018 DONE (one cycle): load buttons from the shift register and dpad = {buttons[0], buttons[3], buttons[2], buttons[1]} atomically, and assert valid for that cycle only; then return to IDLE.
REQ-019 buttons and dpad SHALL hold their value between DONE cycles; partially shifted data is never visible on the outputs.
REQ-020 The poll counter SHALL run in all states so that latch-to-latch spacing is exactly POLL_CYCLES.
REQ-021 Simultaneous opposing directions (left+right, up+down) SHALL be reported unfiltered.

Reset
REQ-022 While reset=1 at a clk edge: state=IDLE, poll counter=0, index=0, shift register=0, synchronizer flops=1, nes_latch=0, nes_clk=0, buttons=0, dpad=0, valid=0.
REQ-023 Reset mid-frame SHALL abort the frame without a valid pulse; first nes_latch rise occurs POLL_CYCLES clk edges after reset deasserts.

Structure
REQ-024 A shared package frogger_pkg SHALL hold the state enum and the button bit-index constants (BTN_A..BTN_RIGHT, DPAD_LEFT..DPAD_RIGHT).
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff; all other logic is in nes_controller.

Verification (HALF_DIV=2, POLL_CYCLES=64)
REQ-026 Reset held, then released -> all outputs 0; nes_latch rises 64 edges after release, high 8 cycles; next rise 64 cycles after that.
REQ-027 Controller model, only Up pressed -> after frame, buttons=8'b0000_1000, dpad=4'b0100, valid high exactly one cycle, 41 cycles after latch rise.
REQ-028 nes_data held 1 (nothing pressed) -> buttons=8'h00, dpad=4'b0000, valid still pulses once per frame.
REQ-029 A+Left+Right pressed -> buttons=8'b1000_0011, dpad=4'b1001.
REQ-030 reset pulsed during the 5th nes_clk pulse after a prior Up frame -> next cycle nes_clk=0, nes_latch=0, buttons=0, dpad=0, no valid; next latch 64 edges later.
REQ-031 Count per frame -> exactly 8 nes_clk rising edges spaced 4 cycles; nes_clk never high while nes_latch high.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and constants for the frogger input path: NES controller FSM states and the
// bit positions of each button and d-pad direction.
`timescale 1ns/1ps
package frogger_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StLow,
    StHigh,
    StDone
  } nes_state_e;

  localparam int unsigned BTN_A      = 7;
  localparam int unsigned BTN_B      = 6;
  localparam int unsigned BTN_SELECT = 5;
  localparam int unsigned BTN_START  = 4;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_RIGHT  = 0;

  localparam int unsigned DPAD_LEFT  = 0;
  localparam int unsigned DPAD_DOWN  = 1;
  localparam int unsigned DPAD_UP    = 2;
  localparam int unsigned DPAD_RIGHT = 3;

  // Opposing directions pass through unfiltered; the game logic decides what they mean.
  function automatic logic [3:0] to_dpad(input logic [7:0] btn);
    logic [3:0] d;
    d             = '0;
    d[DPAD_LEFT]  = btn[BTN_LEFT];
    d[DPAD_DOWN]  = btn[BTN_DOWN];
    d[DPAD_UP]    = btn[BTN_UP];
    d[DPAD_RIGHT] = btn[BTN_RIGHT];
    return d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit, with a selectable reset value.
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nes_controller.sv
// NES controller poller: strobes latch at a fixed rate, clocks out 8 serial bits and publishes
// the decoded buttons and d-pad atomically with a one-cycle valid pulse.
`timescale 1ns/1ps
module nes_controller
  import frogger_pkg::*;
#(
  parameter int unsigned HALF_DIV    = 75,
  parameter int unsigned POLL_CYCLES = 416667
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic [3:0] dpad,
  output logic       valid
);

  localparam int unsigned PollW = $clog2(POLL_CYCLES);
  localparam int unsigned PhW   = $clog2(4 * HALF_DIV);

  localparam logic [PollW-1:0] PollLast  = PollW'(POLL_CYCLES - 1);
  localparam logic [PhW-1:0]   LatchLast = PhW'(4 * HALF_DIV - 1);
  localparam logic [PhW-1:0]   HalfLast  = PhW'(HALF_DIV - 1);

  nes_state_e       state_q, state_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic [PhW-1:0]   ph_q, ph_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       buttons_q, buttons_d;
  logic [3:0]       dpad_q, dpad_d;
  logic             valid_q, valid_d;
  logic             data_sync;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i(clk),
    .rst_i(reset),
    .d_i  (nes_data),
    .q_o  (data_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      poll_q    <= '0;
      ph_q      <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      dpad_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      poll_q    <= poll_d;
      ph_q      <= ph_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      dpad_q    <= dpad_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q + PhW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    dpad_d    = dpad_q;
    valid_d   = 1'b0;
    // Free-running in every state so latch-to-latch spacing never depends on frame length.
    poll_d    = (poll_q == PollLast) ? '0 : poll_q + PollW'(1);

    unique case (state_q)
      StIdle: begin
        ph_d = '0;
        if (poll_q == PollLast) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        if (ph_q == LatchLast) begin
          state_d = StLow;
          ph_d    = '0;
          idx_d   = '0;
        end
      end
      StLow: begin
        if (ph_q == HalfLast) begin
          shift_d[3'd7 - idx_q] = ~data_sync;
          state_d               = StHigh;
          ph_d                  = '0;
        end
      end
      StHigh: begin
        if (ph_q == HalfLast) begin
          ph_d = '0;
          if (idx_q != 3'd7) begin
            idx_d   = idx_q + 3'd1;
            state_d = StLow;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        buttons_d = shift_q;
        dpad_d    = to_dpad(shift_q);
        valid_d   = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    nes_latch = (state_q == StLatch);
    nes_clk   = (state_q == StHigh);
    buttons   = buttons_q;
    dpad      = dpad_q;
    valid     = valid_q;
  end

endmodule
